// File: rtl/parking_pkg.sv
// parking_pkg: shared parking-lot types and defaults.
// Gate FSM encoding plus lot sizing used by gate and display.
package parking_pkg;

  localparam int CAPACITY_DEF     = 8;
  localparam int CNT_W_DEF        = 4;
  localparam int MOVE_CYCLES_DEF  = 16;
  localparam int PASS_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OPENING   = 3'd1,
    S_WAIT_PASS = 3'd2,
    S_PASSING   = 3'd3,
    S_CLOSING   = 3'd4
  } gate_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/req_latch.sv
// req_latch: rising-edge detector with a sticky pending flag.
// A blocked edge is reported as refused instead of latched.
module req_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_block,
  input  logic i_clr,
  output logic o_pend,
  output logic o_refused
);

  logic r_s;
  logic r_d;
  logic r_pend;
  logic w_edge;

  assign w_edge    = r_s & ~r_d;
  assign o_pend    = r_pend;
  assign o_refused = w_edge & i_block;

  // sample history and pending flag; a fresh edge beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= 1'b0;
      r_d    <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_s <= i_req;
      r_d <= r_s;
      if (w_edge && !i_block) begin
        r_pend <= 1'b1;
      end else if (i_clr) begin
        r_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/gate_arbiter.sv
// gate_arbiter: single-lane barrier arbiter for the lot.
// Grants entry/exit, sequences the barrier, tracks free spaces.
module gate_arbiter
  import parking_pkg::*;
#(
  parameter int CAPACITY     = CAPACITY_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int MOVE_CYCLES  = MOVE_CYCLES_DEF,
  parameter int PASS_TIMEOUT = PASS_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entryReq,
  input  logic             exitReq,
  input  logic             passSensor,
  output logic             gateOpen,
  output logic             grantEntry,
  output logic             grantExit,
  output logic [CNT_W-1:0] freeSpaces,
  output logic             full,
  output logic             denied
);

  localparam int TMR_MAX = max2(MOVE_CYCLES, PASS_TIMEOUT);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] MOVE_LD = TMR_W'(MOVE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PASS_LD = TMR_W'(PASS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CAP_V   = CNT_W'(CAPACITY);

  gate_state_t      r_state;
  logic [TMR_W-1:0] r_tmr;
  logic [CNT_W-1:0] r_free;
  logic             r_gate;
  logic             r_gnt_ent;
  logic             r_gnt_ext;
  logic             r_last_exit;
  logic             r_denied;
  logic             r_pass;

  logic w_ent_pend;
  logic w_ext_pend;
  logic w_ent_ref;
  logic w_ext_ref;
  logic w_full;
  logic w_at_cap;
  logic w_idle;
  logic w_ent_ok;
  logic w_ext_ok;
  logic w_tie;
  logic w_pick_exit;
  logic w_grant;
  logic w_ent_clr;
  logic w_ext_clr;
  logic w_ent_drop;
  logic w_tmr_done;

  assign w_full      = (r_free == '0);
  assign w_at_cap    = (r_free == CAP_V);
  assign w_idle      = (r_state == S_IDLE);
  assign w_ent_ok    = w_ent_pend & ~w_full;
  assign w_ext_ok    = w_ext_pend & ~w_at_cap;
  assign w_tie       = w_ent_ok & w_ext_ok;
  assign w_pick_exit = w_ext_ok & (~w_ent_ok | ~r_last_exit);
  assign w_grant     = w_idle & (w_ent_ok | w_ext_ok);
  assign w_tmr_done  = (r_tmr == '0);

  // entry pending left over when the lot filled up is dropped
  assign w_ent_drop = w_idle & w_ent_pend & w_full;
  assign w_ent_clr  = w_idle & w_ent_pend & ~w_pick_exit;
  assign w_ext_clr  = w_idle & w_ext_pend
                    & (w_pick_exit | w_at_cap);

  req_latch u_entry (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (entryReq),
    .i_block   (w_full),
    .i_clr     (w_ent_clr),
    .o_pend    (w_ent_pend),
    .o_refused (w_ent_ref)
  );

  req_latch u_exit (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (exitReq),
    .i_block   (1'b0),
    .i_clr     (w_ext_clr),
    .o_pend    (w_ext_pend),
    .o_refused (w_ext_ref)
  );

  // register the car sensor so the falling edge is seen cleanly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= 1'b0;
    end else begin
      r_pass <= passSensor;
    end
  end

  // one-cycle refusal pulse; exit side is never blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_denied <= 1'b0;
    end else begin
      r_denied <= w_ent_ref | w_ext_ref | w_ent_drop;
    end
  end

  // barrier sequencer with shared phase timer and count commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tmr       <= '0;
      r_free      <= CAP_V;
      r_gate      <= 1'b0;
      r_gnt_ent   <= 1'b0;
      r_gnt_ext   <= 1'b0;
      r_last_exit <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_OPENING;
            r_tmr     <= MOVE_LD;
            r_gate    <= 1'b1;
            r_gnt_ent <= ~w_pick_exit;
            r_gnt_ext <= w_pick_exit;
            if (w_tie) begin
              r_last_exit <= w_pick_exit;
            end
          end
        end
        S_OPENING: begin
          if (w_tmr_done) begin
            r_state <= S_WAIT_PASS;
            r_tmr   <= PASS_LD;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_WAIT_PASS: begin
          if (r_pass) begin
            r_state <= S_PASSING;
          end else if (w_tmr_done) begin
            r_state <= S_CLOSING;
            r_tmr   <= MOVE_LD;
            r_gate  <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        S_PASSING: begin
          if (!r_pass) begin
            r_state <= S_CLOSING;
            r_tmr   <= MOVE_LD;
            r_gate  <= 1'b0;
            if (r_gnt_ent && !w_full) begin
              r_free <= r_free - 1'b1;
            end else if (r_gnt_ext && !w_at_cap) begin
              r_free <= r_free + 1'b1;
            end
          end
        end
        S_CLOSING: begin
          if (w_tmr_done) begin
            r_state   <= S_IDLE;
            r_gnt_ent <= 1'b0;
            r_gnt_ext <= 1'b0;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_gate    <= 1'b0;
          r_gnt_ent <= 1'b0;
          r_gnt_ext <= 1'b0;
        end
      endcase
    end
  end

  assign gateOpen   = r_gate;
  assign grantEntry = r_gnt_ent;
  assign grantExit  = r_gnt_ext;
  assign freeSpaces = r_free;
  assign full       = w_full;
  assign denied     = r_denied;

endmodule

// File: tb/tb_gate_arbiter.sv
// tb_gate_arbiter: scoreboard bench for the barrier arbiter.
// Expected services are queued at stimulus, checked at completion.
module tb_gate_arbiter;

  localparam int CAP  = 8;
  localparam int CW   = 4;
  localparam int MOVE = 16;
  localparam int TMO  = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          entryReq = 1'b0;
  logic          exitReq = 1'b0;
  logic          passSensor = 1'b0;
  logic          gateOpen;
  logic          grantEntry;
  logic          grantExit;
  logic [CW-1:0] freeSpaces;
  logic          full;
  logic          denied;

  always #5 clk = ~clk;

  gate_arbiter #(
    .CAPACITY     (CAP),
    .CNT_W        (CW),
    .MOVE_CYCLES  (MOVE),
    .PASS_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entryReq   (entryReq),
    .exitReq    (exitReq),
    .passSensor (passSensor),
    .gateOpen   (gateOpen),
    .grantEntry (grantEntry),
    .grantExit  (grantExit),
    .freeSpaces (freeSpaces),
    .full       (full),
    .denied     (denied)
  );

  typedef struct {
    logic is_exit;
    int   free;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;

  int n_vec    = 0;
  int n_bad    = 0;
  int n_grant  = 0;
  int n_denied = 0;
  int m_free   = CAP;
  logic pg = 1'b0;
  logic px = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // model: queue one service with its expected count afterwards
  task automatic expect_svc(input logic is_exit, input logic car);
    exp_t e;
    if (car) begin
      if (is_exit) m_free = (m_free < CAP) ? m_free + 1 : CAP;
      else         m_free = m_free - 1;
    end
    e.is_exit = is_exit;
    e.free    = m_free;
    sb.push_back(e);
  endtask

  // monitor: grant rise peeks, grant fall pops and compares
  always @(negedge clk) begin
    if (!rst_n) begin
      pg = 1'b0;
      px = 1'b0;
    end else begin
      if (denied) n_denied++;
      if ((grantEntry | grantExit) && !(pg | px)) begin
        n_grant++;
        chk("gnt_excl", grantEntry & grantExit, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) chk("gnt_side", grantExit, sb[0].is_exit);
      end
      if ((pg | px) && !(grantEntry | grantExit)) begin
        chk("sb_pop_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_pop = sb.pop_front();
          chk("svc_side", px, e_pop.is_exit);
          chk("svc_free", freeSpaces, e_pop.free);
          chk("svc_full", full, e_pop.free == 0);
        end
      end
      pg = grantEntry;
      px = grantExit;
    end
  end

  task automatic pulse(input logic e, input logic x);
    @(negedge clk);
    entryReq = e;
    exitReq  = x;
    repeat (2) @(negedge clk);
    entryReq = 1'b0;
    exitReq  = 1'b0;
  endtask

  task automatic wait_gate(input logic v, input int lim);
    int c;
    c = 0;
    while (gateOpen !== v && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (gateOpen !== v) chk("gate_wait", gateOpen, v);
  endtask

  task automatic wait_idle(input int lim);
    int c;
    c = 0;
    while ((grantEntry | grantExit) && c < lim) begin
      @(negedge clk);
      c++;
    end
    if (grantEntry | grantExit) chk("idle_wait", 1, 0);
  endtask

  task automatic serve_car();
    wait_gate(1'b1, 10);
    repeat (MOVE + 3) @(negedge clk);
    passSensor = 1'b1;
    repeat (5) @(negedge clk);
    passSensor = 1'b0;
    wait_idle(300);
    @(negedge clk);
  endtask

  task automatic quiet_window(input string tag, input int g0);
    int seen;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (gateOpen) seen = 1;
    end
    chk({tag, "_nogrant"}, n_grant - g0, 0);
    chk({tag, "_gate"}, seen, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int g0;
    int d0;

    repeat (3) @(negedge clk);
    chk("rst_gate", gateOpen, 0);
    chk("rst_gent", grantEntry, 0);
    chk("rst_gext", grantExit, 0);
    chk("rst_denied", denied, 0);
    chk("rst_free", freeSpaces, CAP);
    chk("rst_full", full, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // entry, with request latency and close-phase length
    expect_svc(1'b0, 1'b1);
    entryReq = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_n1_gate", gateOpen, 0);
    @(posedge clk);
    #1 chk("lat_n2_gate", gateOpen, 1);
    chk("lat_n2_gent", grantEntry, 1);
    @(negedge clk);
    entryReq = 1'b0;
    repeat (MOVE + 2) @(negedge clk);
    passSensor = 1'b1;
    repeat (5) @(negedge clk);
    passSensor = 1'b0;
    wait_gate(1'b0, 20);
    chk("commit_at_close", freeSpaces, 7);
    cnt = 0;
    while ((grantEntry | grantExit) && cnt < 40) begin
      @(posedge clk);
      #1 cnt++;
    end
    chk("close_len", cnt, MOVE);
    @(negedge clk);

    // fill the lot, then a refused entry
    for (int i = 0; i < CAP - 1; i++) begin
      expect_svc(1'b0, 1'b1);
      pulse(1'b1, 1'b0);
      serve_car();
    end
    chk("lot_full", full, 1);
    chk("lot_free0", freeSpaces, 0);
    g0 = n_grant;
    d0 = n_denied;
    pulse(1'b1, 1'b0);
    quiet_window("full", g0);
    chk("full_denied", n_denied - d0, 1);

    // five exits to reach 5 free
    for (int i = 0; i < 5; i++) begin
      expect_svc(1'b1, 1'b1);
      pulse(1'b0, 1'b1);
      serve_car();
    end
    chk("free5", freeSpaces, 5);

    // first tie: exit wins, then entry
    expect_svc(1'b1, 1'b1);
    expect_svc(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    serve_car();
    serve_car();
    chk("tie1_free", freeSpaces, 5);

    // second tie: entry wins, then exit
    expect_svc(1'b0, 1'b1);
    expect_svc(1'b1, 1'b1);
    pulse(1'b1, 1'b1);
    serve_car();
    serve_car();
    chk("tie2_free", freeSpaces, 5);

    // pass timeout: no car, count unchanged
    expect_svc(1'b0, 1'b0);
    pulse(1'b1, 1'b0);
    wait_gate(1'b1, 10);
    cnt = 0;
    while (gateOpen && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("timeout_len", cnt, MOVE + TMO);
    wait_idle(100);
    @(negedge clk);
    chk("timeout_free", freeSpaces, 5);

    // back to an empty lot, then exit on empty
    for (int i = 0; i < 3; i++) begin
      expect_svc(1'b1, 1'b1);
      pulse(1'b0, 1'b1);
      serve_car();
    end
    chk("empty_free", freeSpaces, CAP);
    g0 = n_grant;
    pulse(1'b0, 1'b1);
    quiet_window("empty", g0);
    chk("empty_free_after", freeSpaces, CAP);

    // reset while a car is under the barrier
    expect_svc(1'b0, 1'b1);
    pulse(1'b1, 1'b0);
    wait_gate(1'b1, 10);
    repeat (MOVE + 3) @(negedge clk);
    passSensor = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_gate", gateOpen, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    m_free = CAP;
    #1 chk("rst_mid_gate", gateOpen, 0);
    chk("rst_mid_gent", grantEntry, 0);
    chk("rst_mid_free", freeSpaces, CAP);
    passSensor = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    g0 = n_grant;
    quiet_window("post_rst", g0);
    chk("post_rst_free", freeSpaces, CAP);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
